// File: rtl/cordic_req_ctrl.sv
// Requester side of the CORDIC start/done handshake: one angle in flight, result held on valid/ready.
// Define CORDIC_TIMEOUT_EN to build the WAIT-state watchdog that aborts a job after TIMEOUT_CYCLES.
module cordic_req_ctrl #(
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_angle_i,
   output logic [DATA_W-1:0] angle_o,
   output logic              start_cordic_o,
   input  logic              done_tick_cordic_i,
   input  logic [DATA_W-1:0] cos_i,
   input  logic [DATA_W-1:0] sin_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_cos_o,
   output logic [DATA_W-1:0] out_sin_o,
   output logic              out_err_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

   state_t state;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("cordic_req_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   // Handshake outputs decode the state register only, so they never glitch with inputs.
   assign in_ready_o     = (state == IDLE);
   assign start_cordic_o = (state == START);
   assign out_valid_o    = (state == HOLD);
   assign busy_o         = (state != IDLE);

`ifdef CORDIC_TIMEOUT_EN
   // wait_cnt holds the number of WAIT cycles already completed, so the last
   // permitted cycle is TIMEOUT_CYCLES-1 and a done tick there still wins.
   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             expired;

   assign expired = (wait_cnt == CNT_LAST);
`else
   assign out_err_o = 1'b0;
`endif

   // NOTE: state and data registers use <= only, so every branch sees the pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         angle_o   <= '0;
         out_cos_o <= '0;
         out_sin_o <= '0;
`ifdef CORDIC_TIMEOUT_EN
         out_err_o <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  angle_o <= in_angle_i;
                  state   <= START;
               end
            end
            START: begin
`ifdef CORDIC_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (done_tick_cordic_i) begin
                  out_cos_o <= cos_i;
                  out_sin_o <= sin_i;
`ifdef CORDIC_TIMEOUT_EN
                  out_err_o <= 1'b0;
`endif
                  state     <= HOLD;
`ifdef CORDIC_TIMEOUT_EN
               end else if (expired) begin
                  out_cos_o <= '0;
                  out_sin_o <= '0;
                  out_err_o <= 1'b1;
                  state     <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            HOLD: begin
               if (out_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
